// File: rtl/data_memory_pkg.sv
// Shared address-map constants, region decode and screen FIFO entry type for data_memory.
package data_memory_pkg;

    localparam logic [14:0] RAM_BASE  = 15'h0000;
    localparam logic [14:0] RAM_LIMIT = 15'h3FFF;
    localparam logic [14:0] SCR_BASE  = 15'h4000;
    localparam logic [14:0] SCR_LIMIT = 15'h5FFF;
    localparam logic [14:0] KBD_ADDR  = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } scr_entry_t;

    // RAM_BASE is zero, so everything up to RAM_LIMIT is RAM.
    function automatic region_e decode_region(input logic [14:0] addr);
        if (addr <= RAM_LIMIT)
            return REG_RAM;
        else if (addr >= SCR_BASE && addr <= SCR_LIMIT)
            return REG_SCR;
        else if (addr == KBD_ADDR)
            return REG_KBD;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/data_memory_scr.sv
// scr_fifo: synchronous FIFO buffering screen writes toward the display controller.
// The head reads as zero while empty so the display side never sees stale storage.
module scr_fifo
    import data_memory_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  scr_entry_t                 push_entry,
    input  logic                       pop,
    output scr_entry_t                 head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    scr_entry_t          mem_reg [DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic                full;
    logic                empty;
    logic                do_push;
    logic                do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push)
                count_reg <= count_reg - 1'b1;
        end
    end

    assign head  = empty ? '0 : mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/data_memory.sv
// Data-memory stage: RAM, screen write FIFO, keyboard latch and combinational read mux.
// Define SCREEN_SHADOW_EN to keep a readable 8K x 16 shadow copy of the screen region.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_WORDS  = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    output logic        scr_valid,
    input  logic        scr_ready,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    input  logic        kbd_strobe,
    input  logic [15:0] kbd_code,
    output logic        scr_ovf
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    region_e          region;
    logic [15:0]      ram_mem [RAM_WORDS];
    logic [15:0]      kbd_reg;
    logic             ovf_reg;
    logic             scr_push;
    logic             scr_pop;
    logic             fifo_full;
    logic [CW-1:0]    fifo_count;
    scr_entry_t       push_entry;
    scr_entry_t       head;

    assign region     = decode_region(addressM);
    assign scr_push   = writeM && (region == REG_SCR);
    assign scr_pop    = scr_valid && scr_ready;
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign scr_valid  = (fifo_count != '0);
    assign push_entry = '{addr: addressM[12:0], data: outM};

    scr_fifo #(.DEPTH(FIFO_DEPTH)) u_scr_fifo (
        .clk        (clk),
        .srst       (reset),
        .push       (scr_push),
        .push_entry (push_entry),
        .pop        (scr_pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign scr_addr = head.addr;
    assign scr_data = head.data;

    always_ff @(posedge clk) begin
        if (writeM && region == REG_RAM)
            ram_mem[addressM[13:0]] <= outM;
    end

`ifdef SCREEN_SHADOW_EN
    logic [15:0] shadow_mem [8192];

    // Shadow tracks every screen write, including ones the full FIFO drops.
    always_ff @(posedge clk) begin
        if (scr_push)
            shadow_mem[addressM[12:0]] <= outM;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            // A fresh key code takes priority over the CPU acknowledge.
            if (kbd_strobe)
                kbd_reg <= kbd_code;
            else if (writeM && region == REG_KBD)
                kbd_reg <= '0;
            if (scr_push && fifo_full && !scr_pop)
                ovf_reg <= 1'b1;
        end
    end

    assign scr_ovf = ovf_reg;

    always_comb begin
        inM = '0;
        case (region)
            REG_RAM: inM = ram_mem[addressM[13:0]];
`ifdef SCREEN_SHADOW_EN
            REG_SCR: inM = shadow_mem[addressM[12:0]];
`else
            REG_SCR: inM = '0;
`endif
            REG_KBD: inM = kbd_reg;
            default: inM = '0;
        endcase
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: RAM, screen FIFO, keyboard latch, unmapped, reset.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        scr_valid;
    logic        scr_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        kbd_strobe;
    logic [15:0] kbd_code;
    logic        scr_ovf;

    int checks_total  = 0;
    int checks_passed = 0;

    data_memory dut (
        .clk        (clk),
        .reset      (reset),
        .addressM   (addressM),
        .outM       (outM),
        .writeM     (writeM),
        .inM        (inM),
        .scr_valid  (scr_valid),
        .scr_ready  (scr_ready),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .kbd_strobe (kbd_strobe),
        .kbd_code   (kbd_code),
        .scr_ovf    (scr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-14s got=%h exp=%h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        tick();
        writeM   = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [14:0] a, input logic [15:0] exp);
        addressM = a;
        #1;
        check(tag, {16'h0, inM}, {16'h0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        addressM   = '0;
        outM       = '0;
        writeM     = 1'b0;
        scr_ready  = 1'b0;
        kbd_strobe = 1'b0;
        kbd_code   = '0;
        #2;
        do_reset();

        check("rst_valid", {31'h0, scr_valid}, 32'h0);
        check("rst_ovf",   {31'h0, scr_ovf},   32'h0);
        check("rst_addr",  {19'h0, scr_addr},  32'h0);
        check("rst_data",  {16'h0, scr_data},  32'h0);
        cpu_read("rst_kbd", 15'h6000, 16'h0000);

        // RAM: neighbour written first so its value is known.
        cpu_write(15'h0011, 16'h5555);
        cpu_write(15'h0010, 16'h1234);
        cpu_read("ram_0010", 15'h0010, 16'h1234);
        cpu_read("ram_0011", 15'h0011, 16'h5555);

        // Screen fill with display stalled.
        cpu_write(15'h4000, 16'h1110);
        check("scr_valid1", {31'h0, scr_valid}, 32'h1);
        check("scr_head1", {3'h0, scr_addr, scr_data}, {3'h0, 13'h0000, 16'h1110});
        for (int i = 1; i < 4; i++) cpu_write(15'h4000 + 15'(i), 16'h1110 + 16'(i));
        check("scr_head4", {3'h0, scr_addr, scr_data}, {3'h0, 13'h0000, 16'h1110});
        check("ovf_before", {31'h0, scr_ovf}, 32'h0);
        cpu_write(15'h4004, 16'hDEAD);
        check("ovf_set", {31'h0, scr_ovf}, 32'h1);
        scr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pop%0d", i), {3'h0, scr_addr, scr_data},
                  {3'h0, 13'(i), 16'h1110 + 16'(i)});
            tick();
        end
        check("drain_valid", {31'h0, scr_valid}, 32'h0);
        check("ovf_sticky", {31'h0, scr_ovf}, 32'h1);
        scr_ready = 1'b0;

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) cpu_write(15'h4000 + 15'(i), 16'h2220 + 16'(i));
        scr_ready = 1'b1;
        cpu_write(15'h4010, 16'hBEEF);
        scr_ready = 1'b0;
        check("pp_full_ovf", {31'h0, scr_ovf}, 32'h0);
        check("pp_full_head", {3'h0, scr_addr, scr_data}, {3'h0, 13'h0001, 16'h2221});
        scr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check($sformatf("pp_pop%0d", i), {3'h0, scr_addr, scr_data},
                  {3'h0, 13'(i), 16'h2220 + 16'(i)});
            tick();
        end
        check("pp_pop_new", {3'h0, scr_addr, scr_data}, {3'h0, 13'h0010, 16'hBEEF});
        tick();
        check("pp_empty", {31'h0, scr_valid}, 32'h0);

        // Empty FIFO: push with ready high, no bypass.
        addressM = 15'h4005;
        outM     = 16'h0F0F;
        writeM   = 1'b1;
        #1;
        check("byp_none", {31'h0, scr_valid}, 32'h0);
        tick();
        writeM = 1'b0;
        check("byp_next", {3'h0, scr_addr, scr_data}, {3'h0, 13'h0005, 16'h0F0F});
        check("byp_valid", {31'h0, scr_valid}, 32'h1);
        tick();
        check("byp_popped", {31'h0, scr_valid}, 32'h0);
        scr_ready = 1'b0;

        // Keyboard latch, acknowledge, and strobe-wins collision.
        kbd_strobe = 1'b1;
        kbd_code   = 16'h0041;
        tick();
        kbd_strobe = 1'b0;
        cpu_read("kbd_load", 15'h6000, 16'h0041);
        cpu_write(15'h6000, 16'h1234);
        cpu_read("kbd_ack", 15'h6000, 16'h0000);
        kbd_strobe = 1'b1;
        kbd_code   = 16'h0042;
        cpu_write(15'h6000, 16'h0000);
        kbd_strobe = 1'b0;
        cpu_read("kbd_win", 15'h6000, 16'h0042);

        // Unmapped address: no RAM alias, no FIFO entry.
        cpu_write(15'h2005, 16'h7777);
        cpu_write(15'h6005, 16'hFFFF);
        cpu_read("unm_read", 15'h6005, 16'h0000);
        cpu_read("unm_ram", 15'h2005, 16'h7777);
        check("unm_fifo", {31'h0, scr_valid}, 32'h0);
        cpu_read("unm_hi", 15'h7FFF, 16'h0000);

        // Reset with traffic pending.
        do_reset();
        for (int i = 0; i < 5; i++) cpu_write(15'h4000 + 15'(i), 16'hAAAA);
        kbd_strobe = 1'b1;
        kbd_code   = 16'h0051;
        tick();
        kbd_strobe = 1'b0;
        check("pre_rst_ovf", {31'h0, scr_ovf}, 32'h1);
        do_reset();
        check("mrst_valid", {31'h0, scr_valid}, 32'h0);
        check("mrst_ovf",   {31'h0, scr_ovf},   32'h0);
        check("mrst_head",  {3'h0, scr_addr, scr_data}, 32'h0);
        cpu_read("mrst_kbd", 15'h6000, 16'h0000);
        cpu_read("ram_keep", 15'h0010, 16'h1234);
`ifdef SCREEN_SHADOW_EN
        cpu_read("scr_read", 15'h4000, 16'hAAAA);
`else
        cpu_read("scr_read", 15'h4000, 16'h0000);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
